// File: rtl/pc_pkg.sv
// Shared types for the PC/fetch stage: FSM states, next-PC select codes and default vectors.
// Pure declarations; no latency or flow control of its own.
package pc_pkg;

    localparam int PC_XLEN = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_TRAP
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JAL,
        SEL_JALR
    } pc_sel_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request bus: controller raises imem_req with imem_addr, memory answers with imem_ready.
// Ready may take any number of cycles; address is held stable while req is high.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready
    );
endinterface

// File: rtl/pc_target_calc.sv
// Next-PC select, adders and misalignment check; purely combinational, zero latency.
// No handshake: outputs follow inputs every cycle.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN = PC_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            is_branch,
    input  logic            branch_next,
    input  logic            is_jal,
    input  logic            is_jalr,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] target,
    output pc_sel_t         sel,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] reg_rel;

    // All sums wrap modulo 2^XLEN by construction of the operand width.
    assign pc_plus4 = pc + XLEN'(4);
    assign pc_rel   = pc + imm;
    assign reg_rel  = rs1_val + imm;

    always_comb begin
        sel = SEL_SEQ;
        if (is_jalr) begin
            sel = SEL_JALR;
        end else if (is_jal) begin
            sel = SEL_JAL;
        end else if (is_branch && branch_next) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        target = pc_plus4;
        case (sel)
            SEL_JALR: target = {reg_rel[XLEN-1:1], 1'b0};
            SEL_JAL:  target = pc_rel;
            SEL_BR:   target = pc_rel;
            default:  target = pc_plus4;
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register + fetch/exec/trap FSM driving imem req/ready; PC_STATS_EN adds taken/retired counters.
// Fetch holds req until imem_ready (unbounded); next PC registers one cycle after exec_done.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN      = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_next,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic              exec_done,
    pc_fetch_ctrl_if.master   imem,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              instr_valid,
    output logic              trap
`ifdef PC_STATS_EN
    ,
    output logic [31:0]       cnt_taken,
    output logic [31:0]       cnt_retired
`endif
);

    pc_state_t       state;
    pc_state_t       state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            instr_valid_nxt;
    logic            req;
    logic [XLEN-1:0] target;
    pc_sel_t         sel;
    logic            misaligned;

    pc_target_calc #(
        .XLEN (XLEN)
    ) u_target (
        .pc          (pc),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .is_branch   (is_branch),
        .branch_next (branch_next),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .pc_plus4    (pc_plus4),
        .target      (target),
        .sel         (sel),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_VEC;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= instr_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_valid_nxt = 1'b0;
        req             = 1'b0;
        trap            = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    instr_valid_nxt = 1'b1;
                    state_nxt       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    // A misaligned target leaves pc untouched; the trap cycle redirects it.
                    if (misaligned) begin
                        state_nxt = S_TRAP;
                    end else begin
                        pc_nxt    = target;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                trap      = 1'b1;
                pc_nxt    = TRAP_VEC;
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

`ifdef PC_STATS_EN
    logic retire;
    logic taken;

    assign retire = (state == S_EXEC) && exec_done;
    assign taken  = retire && !misaligned && (sel != SEL_SEQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_taken   <= 32'd0;
            cnt_retired <= 32'd0;
        end else begin
            if (retire) begin
                cnt_retired <= sat_inc32(cnt_retired);
            end
            if (taken) begin
                cnt_taken <= sat_inc32(cnt_taken);
            end
        end
    end
`else
    logic unused_sel;
    assign unused_sel = ^sel;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: abstract per-cycle model plus hand-computed spot checks.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        branch_next;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        exec_done;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        trap;
`ifdef PC_STATS_EN
    logic [31:0] cnt_taken;
    logic [31:0] cnt_retired;
`endif

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    pc_fetch_ctrl_if #(.XLEN(32)) imem_bus ();

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .branch_next (branch_next),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .exec_done   (exec_done),
        .imem        (imem_bus),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .trap        (trap)
`ifdef PC_STATS_EN
        ,
        .cnt_taken   (cnt_taken),
        .cnt_retired (cnt_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for instruction, 1 = executing, 2 = trap cycle.
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_iv;
    longint      m_taken;
    longint      m_retired;

    function automatic logic [31:0] next_pc(input logic [31:0] cur);
        longint t;
        if (is_jalr) begin
            t = longint'({32'b0, rs1_val}) + longint'({32'b0, imm});
            t = t - (t % 2);
        end else if (is_jal || (is_branch && branch_next)) begin
            t = longint'({32'b0, cur}) + longint'({32'b0, imm});
        end else begin
            t = longint'({32'b0, cur}) + 4;
        end
        return t[31:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   = 0;
            m_pc      = RESET_VEC;
            m_iv      = 0;
            m_taken   = 0;
            m_retired = 0;
        end else begin
            logic [31:0] t;
            m_iv = 0;
            if (m_phase == 0) begin
                if (imem_bus.imem_ready) begin
                    m_iv    = 1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (exec_done) begin
                    t = next_pc(m_pc);
                    if (m_retired < 64'hFFFF_FFFF) m_retired++;
                    if (t % 4 != 0) begin
                        m_phase = 2;
                    end else begin
                        if ((is_jalr || is_jal || (is_branch && branch_next)) &&
                            m_taken < 64'hFFFF_FFFF) m_taken++;
                        m_pc    = t;
                        m_phase = 0;
                    end
                end
            end else begin
                m_pc    = TRAP_VEC;
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_bus.imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, m_phase == 0});
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_iv});
            chk("trap", {31'b0, trap}, {31'b0, m_phase == 2});
`ifdef PC_STATS_EN
            chk("cnt_taken", cnt_taken, m_taken[31:0]);
            chk("cnt_retired", cnt_retired, m_retired[31:0]);
`endif
        end
    end

    task automatic clear_flags();
        is_branch   = 0;
        branch_next = 0;
        is_jal      = 0;
        is_jalr     = 0;
        imm         = 32'h0;
        rs1_val     = 32'h0;
    endtask

    // gap idle cycles (with a stray exec_done that must be ignored), then one ready cycle.
    task automatic fetch(input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); #1;
            imem_bus.imem_ready = 0;
            exec_done           = 1;
        end
        @(negedge clk); #1;
        imem_bus.imem_ready = 1;
        exec_done           = 0;
        @(negedge clk); #1;
        imem_bus.imem_ready = 0;
    endtask

    // gap idle cycles (with a stray imem_ready that must be ignored), then exec_done with flags.
    task automatic exec(input int gap, input bit br, input bit bn, input bit jal, input bit jalr,
                        input logic [31:0] im, input logic [31:0] rs1);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); #1;
            imem_bus.imem_ready = 1;
            exec_done           = 0;
        end
        @(negedge clk); #1;
        imem_bus.imem_ready = 0;
        exec_done   = 1;
        is_branch   = br;
        branch_next = bn;
        is_jal      = jal;
        is_jalr     = jalr;
        imm         = im;
        rs1_val     = rs1;
        @(negedge clk); #1;
        exec_done = 0;
        clear_flags();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        exec_done = 0;
        imem_bus.imem_ready = 0;
        clear_flags();
        #12;
        chk("rst_pc", pc, RESET_VEC);
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd1);
        chk("rst_addr", imem_bus.imem_addr, 32'h0);
        chk("rst_iv", {31'b0, instr_valid}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        @(negedge clk); #1;
        rst = 0;
        started = 1;

        // Ready arrives on the second fetch cycle.
        fetch(1);
        chk("t1_iv", {31'b0, instr_valid}, 32'd1);
        chk("t1_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("t1_addr", imem_bus.imem_addr, 32'h0);

        exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        fetch(0); exec(2, 0, 0, 0, 0, 32'h0, 32'h0);
        fetch(2); exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        fetch(0); exec(1, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("pc_at_0x10", pc, 32'h10);
        fetch(0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("t2_seq_addr", imem_bus.imem_addr, 32'h14);

        fetch(0); exec(0, 0, 0, 1, 0, 32'hC, 32'h0);
        chk("jal_to_0x20", pc, 32'h20);
        fetch(0); exec(0, 1, 1, 0, 0, -32'sd8, 32'h0);
        chk("t3_br_taken", pc, 32'h18);
        fetch(0); exec(0, 0, 0, 1, 0, 32'h8, 32'h0);
        fetch(0); exec(0, 1, 0, 0, 0, -32'sd8, 32'h0);
        chk("t3_br_not_taken", pc, 32'h24);

        fetch(1); exec(0, 0, 0, 1, 1, 32'h3, 32'h101);
        chk("t4_jalr_wins", pc, 32'h104);

        fetch(0); exec(0, 0, 0, 1, 0, -32'sh0C4, 32'h0);
        chk("pc_at_0x40", pc, 32'h40);
        fetch(0); exec(0, 0, 0, 1, 0, 32'h2, 32'h0);
        chk("t5_trap_pulse", {31'b0, trap}, 32'd1);
        chk("t5_pc_held", pc, 32'h40);
        @(negedge clk); #1;
        chk("t5_trap_end", {31'b0, trap}, 32'd0);
        chk("t5_trap_addr", imem_bus.imem_addr, TRAP_VEC);

        // jalr with bit 1 set in the target also traps.
        fetch(0); exec(0, 0, 0, 0, 1, 32'h0, 32'h102);
        chk("jalr_misalign_trap", {31'b0, trap}, 32'd1);
        @(negedge clk); #1;

        // Wrapping sums: rs1+imm overflows, then pc+4 wraps to zero.
        fetch(0); exec(0, 0, 0, 0, 1, -32'sd2, 32'hFFFF_FFFF);
        chk("jalr_wrap", pc, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        fetch(0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("seq_wrap", pc, 32'h0);

        fetch(0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        fetch(0);
        chk("pre_rst_pc", pc, 32'h4);

        // Reset lands mid-cycle while a trapping exec_done is presented.
        @(negedge clk); #1;
        exec_done = 1;
        is_jal    = 1;
        imm       = 32'h2;
        #2 rst = 1;
        #1;
        chk("t6_pc", pc, RESET_VEC);
        chk("t6_trap", {31'b0, trap}, 32'd0);
        chk("t6_iv", {31'b0, instr_valid}, 32'd0);
        chk("t6_req", {31'b0, imem_bus.imem_req}, 32'd1);
        @(negedge clk); #1;
        rst = 0;
        exec_done = 0;
        clear_flags();
        @(negedge clk); #1;
        chk("t6_post_trap", {31'b0, trap}, 32'd0);
        fetch(0); exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("t6_resume", pc, 32'h4);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
